dicke_integrator: RTL
=====================

# dicke_integrator

Parametrised Dicke-switch synchronous demodulator for the radiometer back-end. It generates the antenna/reference switching waveform and accumulates ADC samples separately for each switch phase over N full switch cycles. It then presents the signed difference (antenna − reference) through a valid/ready handshake to the UART framer. It replaces the fixed clock-divider plus ADC path with one block that sets period, integration length and sample width at instantiation.

## Interface
- `SAMPLE_W`, 12: ADC sample width, unsigned.
- `ACC_W`, 32: per-phase accumulator width. Must satisfy ACC_W ≥ SAMPLE_W + clog2(N_CYCLES·HALF_PERIOD).
- `HALF_PERIOD`, 50000: clk cycles per switch half-period (1 kHz at 100 MHz). Minimum 2.
- `N_CYCLES`, 16: full switch cycles per integration. Minimum 1.
- `BLANK_CYCLES`, 1000: settling cycles discarded after each switch edge (only with blanking compiled in). Must be < HALF_PERIOD.
- `clk` in 1: 100 MHz system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run switching and integration.
- `sample_valid` in 1: `sample` is valid this cycle.
- `sample` in SAMPLE_W: ADC sample, unsigned.
- `switch_pwm` out 1: 1 = antenna phase, 0 = reference phase. Registered.
- `result_valid` out 1: `result_diff` holds an untransferred result.
- `result_ready` in 1: consumer accepts the result.
- `result_diff` out ACC_W+1: signed acc_ant − acc_ref.
- `overrun` out 1: sticky flag; a result was overwritten before transfer. Cleared only by reset.
- `busy` out 1: high in RUN.

## Operation
- Reset values: switch_pwm=0, result_valid=0, result_diff=0, overrun=0, busy=0. Internal phase_cnt, cycle_cnt, acc_ant and acc_ref are all 0. State is IDLE.
- IDLE to RUN:
  - Transition happens on the edge that samples enable=1.
  - On that edge: switch_pwm←1, phase_cnt←0, cycle_cnt←0, accumulators←0.
- RUN, each edge:
  - phase_cnt increments.
  - When phase_cnt==HALF_PERIOD-1: phase_cnt←0 and switch_pwm toggles.
- Sample accumulation:
  - A sample is accepted on an edge when sample_valid=1 (subject to blanking).
  - It is added to acc_ant if the current switch_pwm=1, else to acc_ref.
  - Accumulators are unsigned ACC_W; overflow wraps modulo 2^ACC_W. The width rule above prevents this.
- Cycle completion:
  - A cycle ends on the edge where phase_cnt==HALF_PERIOD-1 and switch_pwm=0. On that edge cycle_cnt increments.
  - If cycle_cnt==N_CYCLES-1 on that edge:
    - result_diff←acc_ant − (acc_ref + accepted sample on that edge), computed sign-extended to ACC_W+1.
    - result_valid←1.
    - Accumulators←0 and cycle_cnt←0.
  - Switching continues without a gap.
- Handshake:
  - A transfer occurs on an edge with result_valid=1 and result_ready=1. result_valid←0 unless a new result loads on the same edge.
  - New result while result_valid=1 and no transfer: overwrite result_diff and set overrun←1.
  - New result on the same edge as a transfer: load the new result, keep result_valid=1, and leave overrun unchanged.
  - result_diff is stable while result_valid=1 and no new load occurs.
- enable=0 in RUN:
  - Next edge goes to IDLE: switch_pwm←0, counters and accumulators cleared.
  - The partial integration is discarded.
  - result_valid, result_diff and overrun are untouched; a pending result can still be transferred in IDLE.
- rst_n low at any time clears everything immediately, asynchronously. Deassertion is assumed synchronised externally.

## Timing
- Switch period = 2·HALF_PERIOD clk cycles, duty 50 %. Antenna phase comes first after enable.
- First result_valid rises 2·HALF_PERIOD·N_CYCLES edges after the edge that samples enable=1.
- Later results follow every 2·HALF_PERIOD·N_CYCLES cycles.
- Every output is a register output; there are no combinational paths from input to output.
- result_ready→result_valid fall takes 1 cycle.

## Configuration
- `DICKE_BLANK_EN` defined:
  - Samples on edges where phase_cnt < BLANK_CYCLES are discarded in both phases.
  - Each half-period then accepts at most HALF_PERIOD−BLANK_CYCLES samples.
- Undefined: every valid sample is accepted, and BLANK_CYCLES is ignored.

## Test plan
All scenarios use SAMPLE_W=8, ACC_W=16, HALF_PERIOD=8, N_CYCLES=2, BLANK_CYCLES=2, and result_ready=1 unless stated.
- Reset: hold rst_n=0 with random inputs -> all outputs 0. Assert rst_n mid-RUN -> all outputs 0 in the same cycle, with no clock edge needed.
- Equal phases: sample=10 every cycle, blanking off -> switch_pwm toggles every 8 cycles; result_valid rises 32 edges after enable; result_diff=0.
- Unequal phases: sample=20 when switch_pwm=1, 5 when switch_pwm=0 -> result_diff=+240 without DICKE_BLANK_EN, +180 with it. Swapping the two values gives −240 / −180.
- Backpressure: result_ready=0 across two results -> second value replaces first, overrun=1 and stays 1. Then result_ready=1 -> one transfer, result_valid low next cycle.
- Abort: drop enable at cycle 20 -> switch_pwm=0 next edge and no result. Re-enable -> first result 32 edges later, with no contribution from pre-abort samples.
- Sparse samples: sample_valid on alternate cycles, antenna=4 and reference=0 -> result_diff=+32 without blanking.

Source files
------------

// File: rtl/dicke_integrator_if.sv
// Sample-in / result-out bundle for the Dicke demodulator.
// master = demodulator side, slave = ADC/framer side.
interface dicke_integrator_if #(
  parameter int SAMPLE_W = 12,
  parameter int ACC_W    = 32
);

  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample;
  logic                result_valid;
  logic                result_ready;
  logic [ACC_W:0]      result_diff;

  modport master (
    input  sample_valid,
    input  sample,
    input  result_ready,
    output result_valid,
    output result_diff
  );

  modport slave (
    output sample_valid,
    output sample,
    output result_ready,
    input  result_valid,
    input  result_diff
  );

endinterface

// File: rtl/dicke_integrator.sv
// Dicke switch generator + per-phase integrator, antenna minus reference.
// Define DICKE_BLANK_EN to drop samples in the settling window after each edge.
module dicke_integrator #(
  parameter int SAMPLE_W     = 12,
  parameter int ACC_W        = 32,
  parameter int HALF_PERIOD  = 50000,
  parameter int N_CYCLES     = 16,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic switch_pwm,
  output logic overrun,
  output logic busy,
  dicke_integrator_if.master bus
);

  localparam int PH_W = $clog2(HALF_PERIOD);
  localparam int CY_W = (N_CYCLES > 1) ? $clog2(N_CYCLES) : 1;

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_PERIOD - 1);
  localparam logic [CY_W-1:0] CY_LAST = CY_W'(N_CYCLES - 1);

  // Elaboration-time sanity of the configuration
  if (HALF_PERIOD < 2) begin : g_bad_half
    $error("HALF_PERIOD must be at least 2");
  end
  if (N_CYCLES < 1) begin : g_bad_ncyc
    $error("N_CYCLES must be at least 1");
  end
  if (BLANK_CYCLES >= HALF_PERIOD) begin : g_bad_blank
    $error("BLANK_CYCLES must be below HALF_PERIOD");
  end
  if (ACC_W < SAMPLE_W) begin : g_bad_acc
    $error("ACC_W narrower than a sample");
  end

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t          state;
  logic [PH_W-1:0] phase_cnt;
  logic [CY_W-1:0] cycle_cnt;
  logic [ACC_W-1:0] acc_ant;
  logic [ACC_W-1:0] acc_ref;

  logic             blank_ok;
  logic             half_end;
  logic             cyc_end;
  logic             last_cyc;
  logic             take;
  logic             load;
  logic [ACC_W-1:0] smp;
  logic [ACC_W-1:0] ant_sum;
  logic [ACC_W-1:0] ref_sum;
  logic [ACC_W:0]   new_diff;

`ifdef DICKE_BLANK_EN
  localparam logic [PH_W-1:0] BLANK_N = PH_W'(BLANK_CYCLES);
  assign blank_ok = (phase_cnt >= BLANK_N);
`else
  assign blank_ok = 1'b1;
`endif

  // Edge detection, sample gating and the candidate result
  always_comb begin
    half_end = (phase_cnt == PH_LAST);
    cyc_end  = half_end && !switch_pwm;
    last_cyc = (cycle_cnt == CY_LAST);
    take     = bus.sample_valid && blank_ok;
    smp      = take ? ACC_W'(bus.sample) : '0;
    ant_sum  = acc_ant + smp;
    ref_sum  = acc_ref + smp;
    // final reference sample lands on the closing edge itself
    new_diff = {1'b0, acc_ant} - {1'b0, ref_sum};
    load     = (state == RUN) && enable
               && cyc_end && last_cyc;
  end

  // Run/idle control, switch waveform, counters and accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      switch_pwm <= 1'b0;
      phase_cnt  <= '0;
      cycle_cnt  <= '0;
      acc_ant    <= '0;
      acc_ref    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (enable) begin
            state      <= RUN;
            busy       <= 1'b1;
            switch_pwm <= 1'b1;
            phase_cnt  <= '0;
            cycle_cnt  <= '0;
            acc_ant    <= '0;
            acc_ref    <= '0;
          end
        end
        RUN: begin
          if (!enable) begin
            state      <= IDLE;
            busy       <= 1'b0;
            switch_pwm <= 1'b0;
            phase_cnt  <= '0;
            cycle_cnt  <= '0;
            acc_ant    <= '0;
            acc_ref    <= '0;
          end else begin
            if (half_end) begin
              phase_cnt  <= '0;
              switch_pwm <= !switch_pwm;
            end else begin
              phase_cnt <= phase_cnt + 1'b1;
            end
            if (load) begin
              cycle_cnt <= '0;
              acc_ant   <= '0;
              acc_ref   <= '0;
            end else begin
              if (cyc_end) begin
                cycle_cnt <= cycle_cnt + 1'b1;
              end
              if (switch_pwm) begin
                acc_ant <= ant_sum;
              end else begin
                acc_ref <= ref_sum;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Result register and valid/ready handshake with sticky overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.result_valid <= 1'b0;
      bus.result_diff  <= '0;
      overrun          <= 1'b0;
    end else if (load) begin
      bus.result_diff  <= new_diff;
      bus.result_valid <= 1'b1;
      if (bus.result_valid && !bus.result_ready) begin
        overrun <= 1'b1;
      end
    end else if (bus.result_valid && bus.result_ready) begin
      bus.result_valid <= 1'b0;
    end
  end

endmodule
